// File: rtl/axi_read_arbiter_pkg.sv
// Shared encodings for the AXI read arbiter: owner ids, FSM states and AXI AR constants.
package axi_read_arbiter_pkg;

    localparam logic [1:0] OWN_NONE    = 2'd0;
    localparam logic [1:0] OWN_ICACHE  = 2'd1;
    localparam logic [1:0] OWN_DCACHE  = 2'd2;
    localparam logic [1:0] OWN_UNCACHE = 2'd3;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StAddr = 2'd1,
        StData = 2'd2,
        StResp = 2'd3
    } state_e;

    localparam logic [2:0] SIZE_4B    = 3'b010;
    localparam logic [1:0] BURST_INCR = 2'b01;

endpackage

// File: rtl/axi_read_arbiter_collector.sv
// Read line collector: packs R beats into a line buffer; beats past the last word are dropped.
module axi_read_arbiter_collector #(
    parameter int unsigned LINE_WORDS = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    clear_i,
    input  logic                    shift_i,
    input  logic [31:0]             data_i,
    output logic [32*LINE_WORDS-1:0] line_o
);
    localparam int unsigned CntW = (LINE_WORDS > 1) ? $clog2(LINE_WORDS) : 1;

    logic [CntW-1:0]           cnt_q, cnt_d;
    logic                      full_q, full_d;
    logic [32*LINE_WORDS-1:0]  line_q, line_d;

    always_comb begin
        cnt_d  = cnt_q;
        full_d = full_q;
        line_d = line_q;
        if (clear_i) begin
            cnt_d  = '0;
            full_d = 1'b0;
            line_d = '0;
        end else if (shift_i && !full_q) begin
            line_d[32*int'(cnt_q) +: 32] = data_i;
            // Counter parks on the last word; full_q then swallows any extra beats.
            if (cnt_q == CntW'(LINE_WORDS - 1)) begin
                full_d = 1'b1;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q  <= '0;
            full_q <= 1'b0;
            line_q <= '0;
        end else begin
            cnt_q  <= cnt_d;
            full_q <= full_d;
            line_q <= line_d;
        end
    end

    assign line_o = line_q;

endmodule

// File: rtl/axi_read_arbiter.sv
// Shares the AXI read channel between icache refill, dcache refill and uncached reads.
// Define ARB_AGE_EN to add an age counter that keeps icache from starving.
module axi_read_arbiter
    import axi_read_arbiter_pkg::*;
#(
    parameter int unsigned LINE_WORDS = 4,
    parameter int unsigned AGE_LIMIT  = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     inst_ren_i,
    input  logic [31:0]              inst_araddr_i,
    output logic                     inst_rvalid_o,
    output logic [32*LINE_WORDS-1:0] inst_rdata_o,
    input  logic                     data_ren_i,
    input  logic [31:0]              data_araddr_i,
    output logic                     data_rvalid_o,
    output logic [32*LINE_WORDS-1:0] data_rdata_o,
    input  logic                     duncache_ren_i,
    input  logic [31:0]              duncache_raddr_i,
    output logic                     duncache_rvalid_o,
    output logic [31:0]              duncache_rdata_o,
    output logic                     dev_rrdy_o,
    output logic                     axi_ren_o,
    output logic [31:0]              axi_raddr_o,
    output logic [7:0]               axi_rlen_o,
    output logic [2:0]               axi_rsize_o,
    input  logic                     axi_arready_i,
    input  logic [31:0]              rdata_i,
    input  logic                     rdata_valid_i,
    input  logic                     rlast_i,
    output logic                     axi_rready_o,
    output logic [1:0]               grant_o
);
    state_e                   state_q, state_d;
    logic [1:0]               owner_q, owner_d;
    logic [31:0]              addr_q, addr_d;
    logic [1:0]               winner;
    logic [32*LINE_WORDS-1:0] line;

`ifdef ARB_AGE_EN
    localparam int unsigned AgeW = $clog2(AGE_LIMIT + 1);
    logic [AgeW-1:0] age_q, age_d;

    always_comb begin
        age_d = age_q;
        if (state_q == StIdle && winner != OWN_NONE) begin
            if (winner == OWN_ICACHE) begin
                age_d = '0;
            end else if (inst_ren_i && age_q < AgeW'(AGE_LIMIT)) begin
                age_d = age_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            age_q <= '0;
        end else begin
            age_q <= age_d;
        end
    end
`else
    logic unused_age;
    assign unused_age = |AGE_LIMIT;
`endif

    always_comb begin
        winner = OWN_NONE;
        if (duncache_ren_i) begin
            winner = OWN_UNCACHE;
        end else if (data_ren_i) begin
            winner = OWN_DCACHE;
        end else if (inst_ren_i) begin
            winner = OWN_ICACHE;
        end
`ifdef ARB_AGE_EN
        if (inst_ren_i && age_q >= AgeW'(AGE_LIMIT)) begin
            winner = OWN_ICACHE;
        end
`endif
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StIdle;
            owner_q <= OWN_NONE;
            addr_q  <= '0;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            addr_q  <= addr_d;
        end
    end

    always_comb begin
        state_d = state_q;
        owner_d = owner_q;
        addr_d  = addr_q;
        unique case (state_q)
            StIdle: begin
                if (winner != OWN_NONE) begin
                    state_d = StAddr;
                    owner_d = winner;
                    case (winner)
                        OWN_UNCACHE: addr_d = duncache_raddr_i;
                        OWN_DCACHE:  addr_d = {data_araddr_i[31:4], 4'h0};
                        default:     addr_d = {inst_araddr_i[31:4], 4'h0};
                    endcase
                end
            end
            StAddr: if (axi_arready_i) state_d = StData;
            StData: if (rdata_valid_i && rlast_i) state_d = StResp;
            StResp: begin
                state_d = StIdle;
                owner_d = OWN_NONE;
            end
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        dev_rrdy_o        = 1'b0;
        axi_ren_o         = 1'b0;
        axi_raddr_o       = '0;
        axi_rlen_o        = '0;
        axi_rready_o      = 1'b0;
        inst_rvalid_o     = 1'b0;
        inst_rdata_o      = '0;
        data_rvalid_o     = 1'b0;
        data_rdata_o      = '0;
        duncache_rvalid_o = 1'b0;
        duncache_rdata_o  = '0;
        unique case (state_q)
            // Masked by rst so every output reads 0 while reset is held.
            StIdle: dev_rrdy_o = ~rst;
            StAddr: begin
                axi_ren_o   = 1'b1;
                axi_raddr_o = addr_q;
                axi_rlen_o  = (owner_q == OWN_UNCACHE) ? 8'd0 : 8'(LINE_WORDS - 1);
            end
            StData: axi_rready_o = 1'b1;
            StResp: begin
                case (owner_q)
                    OWN_ICACHE: begin
                        inst_rvalid_o = 1'b1;
                        inst_rdata_o  = line;
                    end
                    OWN_DCACHE: begin
                        data_rvalid_o = 1'b1;
                        data_rdata_o  = line;
                    end
                    OWN_UNCACHE: begin
                        duncache_rvalid_o = 1'b1;
                        duncache_rdata_o  = line[31:0];
                    end
                    default: ;
                endcase
            end
            default: ;
        endcase
    end

    assign axi_rsize_o = SIZE_4B;
    assign grant_o     = owner_q;

    axi_read_arbiter_collector #(
        .LINE_WORDS(LINE_WORDS)
    ) u_collector (
        .clk     (clk),
        .rst     (rst),
        .clear_i (state_q == StResp),
        .shift_i ((state_q == StData) && rdata_valid_i),
        .data_i  (rdata_i),
        .line_o  (line)
    );

endmodule

// File: tb/tb_axi_read_arbiter.sv
// Scoreboard bench for axi_read_arbiter: directed requests, AXI slave model, pulse monitor.
module tb_axi_read_arbiter;
    logic         clk = 1'b0;
    logic         rst;
    logic         inst_ren, data_ren, duncache_ren;
    logic [31:0]  inst_addr, data_addr, duncache_addr;
    logic         inst_rvalid, data_rvalid, duncache_rvalid;
    logic [127:0] inst_rdata, data_rdata;
    logic [31:0]  duncache_rdata;
    logic         dev_rrdy, axi_ren, axi_arready, rdata_valid, rlast, axi_rready;
    logic [31:0]  axi_raddr, rdata;
    logic [7:0]   axi_rlen;
    logic [2:0]   axi_rsize;
    logic [1:0]   grant;

    typedef struct { logic [1:0] owner; logic [127:0] line; } resp_t;
    typedef struct { logic [31:0] addr; logic [7:0] len; } ar_t;
    typedef struct { int delay; int nbeats; logic [127:0] words; } slv_t;

    resp_t resp_q[$];
    ar_t   ar_q[$];
    slv_t  slv_q[$];

    int vectors = 0;
    int miscompares = 0;
    int data_repeat = 0;

    always #5 clk = ~clk;

    axi_read_arbiter u_dut (
        .clk               (clk),
        .rst               (rst),
        .inst_ren_i        (inst_ren),
        .inst_araddr_i     (inst_addr),
        .inst_rvalid_o     (inst_rvalid),
        .inst_rdata_o      (inst_rdata),
        .data_ren_i        (data_ren),
        .data_araddr_i     (data_addr),
        .data_rvalid_o     (data_rvalid),
        .data_rdata_o      (data_rdata),
        .duncache_ren_i    (duncache_ren),
        .duncache_raddr_i  (duncache_addr),
        .duncache_rvalid_o (duncache_rvalid),
        .duncache_rdata_o  (duncache_rdata),
        .dev_rrdy_o        (dev_rrdy),
        .axi_ren_o         (axi_ren),
        .axi_raddr_o       (axi_raddr),
        .axi_rlen_o        (axi_rlen),
        .axi_rsize_o       (axi_rsize),
        .axi_arready_i     (axi_arready),
        .rdata_i           (rdata),
        .rdata_valid_i     (rdata_valid),
        .rlast_i           (rlast),
        .axi_rready_o      (axi_rready),
        .grant_o           (grant)
    );

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // One granted transaction: slave beats, expected AR and expected response line.
    task automatic add_txn(input logic [1:0] owner, input logic [31:0] addr, input logic [7:0] len,
                           input int delay, input int nbeats, input logic [127:0] words,
                           input logic [127:0] line);
        slv_t  s;
        ar_t   a;
        resp_t r;
        s.delay = delay; s.nbeats = nbeats; s.words = words;
        a.addr = addr; a.len = len;
        r.owner = owner; r.line = line;
        slv_q.push_back(s);
        ar_q.push_back(a);
        resp_q.push_back(r);
    endtask

    task automatic drain(input string name);
        int n = 0;
        while ((resp_q.size() != 0 || ar_q.size() != 0 || grant != 2'd0 || !dev_rrdy) && n < 400) begin
            @(negedge clk);
            n++;
        end
        chk({name, "_timeout"}, 128'(n >= 400), 128'd0);
    endtask

    // AXI slave model.
    initial begin
        slv_t s;
        bit   abort;
        axi_arready = 1'b0; rdata_valid = 1'b0; rlast = 1'b0; rdata = '0;
        forever begin
            @(posedge clk); #1;
            if (!rst && axi_ren && slv_q.size() > 0) begin
                s = slv_q.pop_front();
                abort = 1'b0;
                for (int i = 0; i < s.delay && !abort; i++) begin
                    @(posedge clk); #1;
                    if (rst) abort = 1'b1;
                end
                if (!abort) begin
                    axi_arready = 1'b1;
                    @(posedge clk); #1;
                    axi_arready = 1'b0;
                    if (rst) abort = 1'b1;
                    for (int k = 0; k < s.nbeats && !abort; k++) begin
                        rdata_valid = 1'b1;
                        rdata = s.words[32*k +: 32];
                        rlast = (k == s.nbeats - 1);
                        @(posedge clk); #1;
                        if (rst) abort = 1'b1;
                    end
                end
                axi_arready = 1'b0; rdata_valid = 1'b0; rlast = 1'b0; rdata = '0;
            end
        end
    end

    // Monitor: AR handshakes and rvalid pulses are checked against the queues.
    initial begin
        ar_t          a;
        resp_t        r;
        logic [1:0]   own;
        logic [127:0] got, others;
        int           n;
        forever begin
            @(negedge clk);
            if (axi_ren && axi_arready) begin
                if (ar_q.size() == 0) begin
                    chk("ar_unexpected", {96'd0, axi_raddr}, 128'hFFFF_FFFF_FFFF);
                end else begin
                    a = ar_q.pop_front();
                    chk("ar_addr", {96'd0, axi_raddr}, {96'd0, a.addr});
                    chk("ar_len", {120'd0, axi_rlen}, {120'd0, a.len});
                    chk("ar_size", {125'd0, axi_rsize}, {125'd0, 3'b010});
                end
            end
            n = int'(inst_rvalid) + int'(data_rvalid) + int'(duncache_rvalid);
            if (n != 0) begin
                chk("pulse_onehot", 128'(n), 128'd1);
                if (duncache_rvalid) begin
                    own = 2'd3; got = {96'd0, duncache_rdata}; others = inst_rdata | data_rdata;
                end else if (data_rvalid) begin
                    own = 2'd2; got = data_rdata; others = inst_rdata | {96'd0, duncache_rdata};
                end else begin
                    own = 2'd1; got = inst_rdata; others = data_rdata | {96'd0, duncache_rdata};
                end
                chk("nonowner_rdata", others, 128'd0);
                chk("resp_grant", {126'd0, grant}, {126'd0, own});
                if (resp_q.size() == 0) begin
                    chk("resp_unexpected", {126'd0, own}, 128'd0);
                end else begin
                    r = resp_q.pop_front();
                    chk("resp_owner", {126'd0, own}, {126'd0, r.owner});
                    chk("resp_line", got, r.line);
                end
                if (own == 2'd3) duncache_ren = 1'b0;
                if (own == 2'd1) inst_ren = 1'b0;
                if (own == 2'd2) begin
                    if (data_repeat > 0) data_repeat--;
                    else data_ren = 1'b0;
                end
            end
        end
    end

    initial begin
        int n;
        rst = 1'b1;
        inst_ren = 1'b0; data_ren = 1'b0; duncache_ren = 1'b0;
        inst_addr = '0; data_addr = '0; duncache_addr = '0;
        repeat (2) @(negedge clk);
        chk("rst_rvalids", {125'd0, inst_rvalid, data_rvalid, duncache_rvalid}, 128'd0);
        chk("rst_rdata", inst_rdata | data_rdata | {96'd0, duncache_rdata}, 128'd0);
        chk("rst_dev_rrdy", {127'd0, dev_rrdy}, 128'd0);
        chk("rst_ar", {86'd0, axi_ren, axi_raddr, axi_rlen, axi_rready}, 128'd0);
        chk("rst_rsize", {125'd0, axi_rsize}, {125'd0, 3'b010});
        chk("rst_grant", {126'd0, grant}, 128'd0);
        rst = 1'b0;
        @(negedge clk);
        chk("idle_dev_rrdy", {127'd0, dev_rrdy}, 128'd1);

        // icache refill, address low bits cleared.
        add_txn(2'd1, 32'h1C00_0010, 8'd3, 0, 4,
                128'h00000044_00000033_00000022_00000011,
                128'h00000044_00000033_00000022_00000011);
        @(posedge clk); #1;
        inst_addr = 32'h1C00_0014; inst_ren = 1'b1;
        drain("icache_only");

        // Simultaneous requests: uncache, then dcache, then icache.
        add_txn(2'd3, 32'hBFAF_8004, 8'd0, 0, 1, {96'd0, 32'h5A5A_0001}, {96'd0, 32'h5A5A_0001});
        add_txn(2'd2, 32'h0000_2230, 8'd3, 0, 4,
                128'hD3D3D3D3_D2D2D2D2_D1D1D1D1_D0D0D0D0,
                128'hD3D3D3D3_D2D2D2D2_D1D1D1D1_D0D0D0D0);
        add_txn(2'd1, 32'h1C00_0100, 8'd3, 0, 4,
                128'hC3C3C3C3_C2C2C2C2_C1C1C1C1_C0C0C0C0,
                128'hC3C3C3C3_C2C2C2C2_C1C1C1C1_C0C0C0C0);
        @(posedge clk); #1;
        inst_addr = 32'h1C00_0108; data_addr = 32'h0000_2238; duncache_addr = 32'hBFAF_8004;
        inst_ren = 1'b1; data_ren = 1'b1; duncache_ren = 1'b1;
        drain("three_way");

        // arready held low for 5 cycles.
        add_txn(2'd2, 32'h0000_4000, 8'd3, 5, 4,
                128'h00000004_00000003_00000002_00000001,
                128'h00000004_00000003_00000002_00000001);
        @(posedge clk); #1;
        data_addr = 32'h0000_400C; data_ren = 1'b1;
        n = 0;
        while (!axi_ren && n < 20) begin @(negedge clk); n++; end
        chk("stall_ar_seen", 128'(n >= 20), 128'd0);
        for (int i = 0; i < 5; i++) begin
            chk("stall_ar", {87'd0, axi_ren, axi_raddr, axi_rlen},
                {87'd0, 1'b1, 32'h0000_4000, 8'd3});
            chk("stall_dev_rrdy", {127'd0, dev_rrdy}, 128'd0);
            @(negedge clk);
        end
        drain("stall");

        // Short burst: rlast on beat 2, word 3 stays zero.
        add_txn(2'd2, 32'h8000_0020, 8'd3, 0, 3,
                128'hFFFFFFFF_000000A2_000000A1_000000A0,
                128'h00000000_000000A2_000000A1_000000A0);
        @(posedge clk); #1;
        data_addr = 32'h8000_0028; data_ren = 1'b1;
        drain("short_burst");

        // Async reset during beat 1 of an icache refill; no response expected.
        begin
            slv_t s;
            ar_t  a;
            s.delay = 0; s.nbeats = 4; s.words = 128'h4_3_2_1;
            a.addr = 32'h1C00_0200; a.len = 8'd3;
            slv_q.push_back(s);
            ar_q.push_back(a);
        end
        @(posedge clk); #1;
        inst_addr = 32'h1C00_0204; inst_ren = 1'b1;
        n = 0;
        while (!axi_rready && n < 20) begin @(negedge clk); n++; end
        chk("rst_test_data_seen", 128'(n >= 20), 128'd0);
        @(posedge clk); #2;
        rst = 1'b1; inst_ren = 1'b0;
        #1;
        chk("midrst_ctrl", {122'd0, axi_ren, axi_rready, dev_rrdy, inst_rvalid, grant}, 128'd0);
        chk("midrst_rdata", inst_rdata | {96'd0, axi_raddr}, 128'd0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("postrst_dev_rrdy", {127'd0, dev_rrdy}, 128'd1);
        add_txn(2'd3, 32'h1FD0_0006, 8'd0, 0, 1, {96'd0, 32'hDEAD_BEEF}, {96'd0, 32'hDEAD_BEEF});
        @(posedge clk); #1;
        duncache_addr = 32'h1FD0_0006; duncache_ren = 1'b1;
        drain("after_reset");

`ifdef ARB_AGE_EN
        // dcache back-to-back with icache pending: icache wins the 9th arbitration.
        for (int i = 0; i < 8; i++) begin
            add_txn(2'd2, 32'h0000_3000, 8'd3, 0, 4, {96'd0, 32'hD000_0000 + i},
                    {96'd0, 32'hD000_0000 + i});
        end
        add_txn(2'd1, 32'h1C00_0300, 8'd3, 0, 4, {96'd0, 32'hC000_0009}, {96'd0, 32'hC000_0009});
        for (int i = 8; i < 10; i++) begin
            add_txn(2'd2, 32'h0000_3000, 8'd3, 0, 4, {96'd0, 32'hD000_0000 + i},
                    {96'd0, 32'hD000_0000 + i});
        end
        @(posedge clk); #1;
        data_repeat = 9;
        inst_addr = 32'h1C00_0300; data_addr = 32'h0000_3004;
        inst_ren = 1'b1; data_ren = 1'b1;
        drain("age");
`endif

        repeat (3) @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/axi_read_arbiter.md
Name: axi_read_arbiter

Overview:
- Sequences the single AXI read channel and shares it between three requesters: icache line refill, dcache line refill, and dcache uncached single-word read.
- Sits between icache/dcache and the AXI master interface, in the read half of the cache-to-AXI bridge.
- Grants one requester at a time, issues the AR request, and collects the R beats.
- Cache refills are packed into one 128-bit line; uncached reads return a single word.

Parameters:
LINE_WORDS, 4, 32-bit beats per cache line (line = 32*LINE_WORDS bits)
AGE_LIMIT, 8, consecutive icache losses before forced icache grant (only with ARB_AGE_EN)

Ports:
clk  in  1  clock
rst  in  1  asynchronous active-high reset
inst_ren_i  in  1  icache refill request, level; held until inst_rvalid_o
inst_araddr_i  in  32  icache refill address; stable while inst_ren_i is high
inst_rvalid_o  out  1  one-cycle pulse: line ready
inst_rdata_o  out  128  refill line
data_ren_i  in  1  dcache refill request, level
data_araddr_i  in  32  dcache refill address
data_rvalid_o  out  1  one-cycle pulse: line ready
data_rdata_o  out  128  refill line
duncache_ren_i  in  1  uncached read request, level
duncache_raddr_i  in  32  uncached word address
duncache_rvalid_o  out  1  one-cycle pulse: word ready
duncache_rdata_o  out  32  uncached word
dev_rrdy_o  out  1  high only in IDLE: arbiter can accept a request
axi_ren_o  out  1  AR valid
axi_raddr_o  out  32  AR address
axi_rlen_o  out  8  AR burst length minus one
axi_rsize_o  out  3  AR size, always 3'b010
axi_arready_i  in  1  AR ready
rdata_i  in  32  R data
rdata_valid_i  in  1  R valid
rlast_i  in  1  R last
axi_rready_o  out  1  R ready
grant_o  out  2  current owner: 0 none, 1 icache, 2 dcache, 3 uncache

Behaviour:
- Reset: all outputs 0, except axi_rsize_o = 3'b010. State is IDLE, beat counter 0, line buffer 0. Async reset mid-burst abandons the transaction; the AXI slave is reset by the same signal.
- IDLE:
  - dev_rrdy_o = 1. Requests are sampled every cycle.
  - Fixed priority: uncache > dcache > icache.
  - On any request, latch owner and address, then go to ADDR next cycle.
  - Cache addresses are latched with bits [3:0] cleared. The uncache address is latched unmodified.
- ADDR:
  - axi_ren_o = 1, axi_raddr_o = latched address, axi_rlen_o = LINE_WORDS-1 for cache owners and 0 for uncache.
  - On axi_ren_o && axi_arready_i, go to DATA. Address and len are held stable until then.
- DATA:
  - axi_rready_o = 1.
  - Each rdata_valid_i beat k writes rdata_i into line bits [32k+31:32k]; the beat counter increments.
  - On the beat with rlast_i, go to RESP.
  - A short burst (rlast early) leaves unfilled words 0. Beats beyond LINE_WORDS are dropped; the counter saturates at LINE_WORDS-1.
- RESP:
  - Exactly one cycle. Pulse the owner's rvalid_o; its rdata_o carries the line (uncache: word 0). Non-owner rdata outputs are 0.
  - Then return to IDLE, clear the counter and set grant_o = 0.
  - End-to-end minimum latency from request to rvalid: 3 cycles + AXI latency.
- A request dropped mid-transaction does not abort it; the pulse is still produced.
- A requester re-raising in the same cycle as its rvalid is not granted before the next IDLE cycle.
- grant_o is valid from ADDR through RESP.

Optional Feature:
- Macro: ARB_AGE_EN.
- With it:
  - A saturating age counter increments each IDLE grant cycle where inst_ren_i is high but icache loses.
  - When the counter reaches AGE_LIMIT, icache wins the next IDLE arbitration over both other requesters.
  - The counter clears when icache is granted.
- Without it: pure fixed priority; icache may starve under continuous dcache/uncache traffic.

Decomposition:
- Shared package: owner encoding constants (OWN_NONE/ICACHE/DCACHE/UNCACHE); state encoding (IDLE/ADDR/DATA/RESP); AXI size/burst constants (SIZE_4B = 3'b010, BURST_INCR = 2'b01).
- One natural sub-module: read_line_collector, holding the beat counter and line buffer, with a clear/shift interface.

Test Plan:
- icache only, addr 0x1C00_0014, slave returns 0x11,0x22,0x33,0x44 -> AR addr 0x1C00_0010, len 3; inst_rdata_o = 0x00000044_00000033_00000022_00000011; single inst_rvalid_o pulse.
- inst, data and uncache requests in the same cycle -> grant order uncache (len 0), then dcache, then icache; three pulses, no overlap.
- arready held low 5 cycles -> axi_ren_o, axi_raddr_o and axi_rlen_o stay stable all 5 cycles; dev_rrdy_o = 0 throughout.
- Burst with rlast_i on beat 2 (of 4) -> data_rvalid_o pulses; word 3 = 0.
- Async rst asserted during DATA beat 1 -> outputs 0 immediately; after release, a new request completes normally.
- ARB_AGE_EN, AGE_LIMIT = 8, dcache back-to-back with icache pending -> icache granted on the 9th arbitration; counter returns to 0.
